bcd_ndigit_conv: RTL and testbench

BCD_NDIGIT_CONV -- requirements
Module: bcd_ndigit_conv

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_sub10_step.sv | 17 +
 rtl/bcd_ndigit_conv.sv | 132 +++++++++++++
 tb/tb_bcd_ndigit_conv.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the N-digit binary-to-BCD converter.
// Optional leading-zero blanking in bcd_ndigit_conv is enabled by BCD_LEADING_BLANK_EN.
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_STORE  = 2'd2,
    S_FINISH = 2'd3
  } bcd_state_e;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam int         BCD_RADIX = 10;

  localparam int DIGITS_MIN = 1;
  localparam int DIGITS_MAX = 8;
  localparam int WIDTH_MIN  = 4;
  localparam int WIDTH_MAX  = 27;

endpackage

// File: rtl/bcd_sub10_step.sv
// Combinational compare-and-subtract-by-radix step used by the digit divider.
module bcd_sub10_step
  import bcd_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic [WIDTH-1:0] a,
  output logic             ge10,
  output logic [WIDTH-1:0] diff
);

  always_comb begin
    ge10 = (a >= WIDTH'(BCD_RADIX));
    diff = a - WIDTH'(BCD_RADIX);
  end

endmodule

// File: rtl/bcd_ndigit_conv.sv
// Sequential binary-to-BCD converter: repeated subtract-10 division, one digit per pass.
// Define BCD_LEADING_BLANK_EN to blank leading zero digits (nibble 0 always numeric).
module bcd_ndigit_conv
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    value,
  output logic [4*DIGITS-1:0] digits,
  output logic                busy,
  output logic                valid,
  output logic                overflow,
  output bcd_state_e          o_dbg_state
);

  localparam int                IDX_W    = 4;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

  if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX ||
      WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_param_check
    $error("bcd_ndigit_conv: DIGITS or WIDTH out of supported range");
  end

  bcd_state_e          r_state;
  logic [WIDTH-1:0]    r_dividend;
  logic [WIDTH-1:0]    r_quot;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_shadow;
  logic [4*DIGITS-1:0] r_digits;
  logic                r_busy;
  logic                r_valid;
  logic                r_overflow;
  logic                r_ovf_pend;

  logic                w_ge10;
  logic [WIDTH-1:0]    w_diff;
  logic [4*DIGITS-1:0] w_final;

  bcd_sub10_step #(.WIDTH(WIDTH)) u_step (
    .a    (r_dividend),
    .ge10 (w_ge10),
    .diff (w_diff)
  );

  // Result presented at FINISH; leading digits optionally blanked from the top down.
  always_comb begin
    w_final = r_shadow;
`ifdef BCD_LEADING_BLANK_EN
    begin : blank_scan
      logic w_lead;
      w_lead = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
        if (r_shadow[4*i +: 4] != 4'h0) w_lead = 1'b0;
        if (w_lead) w_final[4*i +: 4] = BCD_BLANK;
      end
    end
`endif
  end

  // start is accepted only in IDLE and ignored while busy; valid is a one-cycle
  // pulse coinciding with the atomic update of digits and overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_dividend <= '0;
      r_quot     <= '0;
      r_idx      <= '0;
      r_shadow   <= '0;
      r_digits   <= {DIGITS{BCD_BLANK}};
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_ovf_pend <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dividend <= value;
            r_quot     <= '0;
            r_idx      <= '0;
            r_shadow   <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          if (w_ge10) begin
            r_dividend <= w_diff;
            r_quot     <= r_quot + WIDTH'(1);
          end else begin
            r_state <= S_STORE;
          end
        end
        S_STORE: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) r_shadow[4*i +: 4] <= r_dividend[3:0];
          end
          r_dividend <= r_quot;
          r_quot     <= '0;
          r_idx      <= r_idx + IDX_W'(1);
          if (r_quot == '0 || r_idx == LAST_IDX) begin
            r_ovf_pend <= (r_quot != '0);
            r_state    <= S_FINISH;
          end else begin
            r_state <= S_DIVIDE;
          end
        end
        S_FINISH: begin
          r_digits   <= r_ovf_pend ? {DIGITS{BCD_BLANK}} : w_final;
          r_overflow <= r_ovf_pend;
          r_valid    <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign digits      = r_digits;
  assign busy        = r_busy;
  assign valid       = r_valid;
  assign overflow    = r_overflow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bcd_ndigit_conv.sv
// Directed plus randomized bench for bcd_ndigit_conv (4-digit and 6-digit instances).
// Expectations follow BCD_LEADING_BLANK_EN when the bench is built with it.
module tb_bcd_ndigit_conv;
  import bcd_pkg::*;

  // clock / reset
  logic clk  = 1'b0;
  logic clk6 = 1'b0;
  always #5 clk  = ~clk;
  always #1 clk6 = ~clk6;

  logic        rst, start;
  logic [13:0] value;
  logic [15:0] digits;
  logic        busy, valid, overflow;
  bcd_state_e  dbg;

  logic        rst6, start6;
  logic [19:0] value6;
  logic [23:0] digits6;
  logic        busy6, valid6, overflow6;
  bcd_state_e  dbg6;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  bcd_ndigit_conv #(.DIGITS(4), .WIDTH(14)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .digits(digits),
    .busy(busy), .valid(valid), .overflow(overflow), .o_dbg_state(dbg)
  );

  bcd_ndigit_conv #(.DIGITS(6), .WIDTH(20)) dut6 (
    .clk(clk6), .rst(rst6), .start(start6), .value(value6), .digits(digits6),
    .busy(busy6), .valid(valid6), .overflow(overflow6), .o_dbg_state(dbg6)
  );

  // reference model: decimal digits by plain arithmetic
  function automatic logic [31:0] model_digits(input int unsigned v, input int nd);
    logic [31:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
`ifdef BCD_LEADING_BLANK_EN
      if (i > 0 && v < p) r[4*i +: 4] = 4'hF;
`endif
      p = p * 10;
    end
    if (v >= p) begin
      for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'hF;
    end
    return r;
  endfunction

  // edges from acceptance (inclusive) to the edge raising valid
  function automatic int model_lat(input int unsigned v, input int nd);
    int unsigned x;
    int c;
    x = v;
    c = 0;
    for (int i = 0; i < nd; i++) begin
      c = c + int'(x / 10) + 2;
      x = x / 10;
      if (x == 0) break;
    end
    return c + 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver: one conversion on the 4-digit instance, optional ignored start mid-way
  task automatic run_conv(input logic [13:0] v, input bit poke);
    int lat;
    int exp_lat;
    bit seen;
    logic [31:0] e;
    exp_q.push_back(model_digits(int'(v), 4));
    exp_lat = model_lat(int'(v), 4);
    @(negedge clk);
    start = 1'b1;
    value = v;
    lat   = 0;
    seen  = 1'b0;
    while (!seen && lat < 4000) begin
      @(posedge clk);
      #1;
      lat++;
      seen = valid;
      if (!seen) begin
        @(negedge clk);
        start = poke && (lat == 20);
        value = 14'($urandom);
      end
    end
    start = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    e = exp_q.pop_front();
    check("digits", 32'(digits), e);
    check("overflow", 32'(overflow), 32'(int'(v) >= 10000));
    check("busy_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("valid_pulse", 32'(valid), 32'd0);
  endtask

  initial begin
    int lat;
    bit seen;
    logic [15:0] last;
    logic [13:0] rv;

    rst = 1'b0; start = 1'b0; value = '0;
    rst6 = 1'b0; start6 = 1'b0; value6 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst  = 1'b1;
    rst6 = 1'b1;
    @(posedge clk);
    #1;
    check("rst_digits", 32'(digits), 32'hFFFF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_state", 32'(dbg), 32'(S_IDLE));
    check("rst6_digits", 32'(digits6), 32'hFFFFFF);

    run_conv(14'd1234, 1'b1);
    check("dir_1234", 32'(digits), 32'h1234);
    run_conv(14'd9999, 1'b0);
    check("dir_9999", 32'(digits), 32'h9999);
    run_conv(14'd10000, 1'b0);
    check("dir_10000", 32'(digits), 32'hFFFF);
    check("dir_10000_ovf", 32'(overflow), 32'd1);
    run_conv(14'd7, 1'b0);
`ifdef BCD_LEADING_BLANK_EN
    check("dir_7", 32'(digits), 32'hFFF7);
`else
    check("dir_7", 32'(digits), 32'h0007);
`endif
    run_conv(14'd0, 1'b0);
`ifdef BCD_LEADING_BLANK_EN
    check("dir_0", 32'(digits), 32'hFFF0);
`else
    check("dir_0", 32'(digits), 32'h0000);
`endif
    last = digits;
    repeat (20) @(posedge clk);
    #1;
    check("hold_digits", 32'(digits), 32'(last));

    for (int k = 0; k < 14; k++) begin
      rv = 14'($urandom_range(0, 12000));
      run_conv(rv, 1'(k % 3 == 0 && rv > 300));
    end

    // abort by reset mid-conversion
    @(negedge clk);
    start = 1'b1;
    value = 14'd5000;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    repeat (29) begin
      @(posedge clk);
      #1;
      if (valid) seen = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_digits", 32'(digits), 32'hFFFF);
    check("abort_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (valid) seen = 1'b1;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    check("abort_digits_after", 32'(digits), 32'hFFFF);

    // reset wins over start in the same cycle
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    value = 14'd42;
    @(posedge clk);
    #1;
    check("prio_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("prio_busy_after", 32'(busy), 32'd0);
    check("prio_state", 32'(dbg), 32'(S_IDLE));
    run_conv(14'd42, 1'b0);

    // six-digit instance on its own fast clock
    @(negedge clk6);
    start6 = 1'b1;
    value6 = 20'd999999;
    lat    = 0;
    seen   = 1'b0;
    while (!seen && lat < 120000) begin
      @(negedge clk6);
      lat++;
      start6 = 1'b0;
      seen   = valid6;
    end
    check("d6_latency", 32'(lat), 32'(model_lat(999999, 6)));
    check("d6_digits", 32'(digits6), 32'h999999);
    check("d6_model", 32'(digits6), model_digits(999999, 6));
    check("d6_overflow", 32'(overflow6), 32'd0);
    check("d6_busy", 32'(busy6), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
